// File: rtl/redmule_tile_pkg.sv
// redmule_tile_pkg: tile-wide iDMA types and dispatcher sizing constants.
package redmule_tile_pkg;

    typedef enum logic {
        AXI2OBI = 1'b0,
        OBI2AXI = 1'b1
    } idma_transfer_ch_e;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] length;
        logic [31:0] src_stride;
        logic [31:0] dst_stride;
        logic [31:0] num_reps;
    } idma_nd_req_t;

    localparam int unsigned iDMA_DispatchNumReq         = 2;
    localparam int unsigned iDMA_DispatchMaxOutstanding = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idma_dispatch_tag_fifo.sv
// idma_dispatch_tag_fifo: in-order FIFO of requester indices awaiting channel completion.
module idma_dispatch_tag_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PtrW-1:0]             rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0]             cnt_q, cnt_d;

    assign full_o  = cnt_q == FullCnt;
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = clear_i ? '0 : !push_i ? wr_q : (wr_q == LastPtr) ? '0 : wr_q + PtrW'(1);
        rd_d  = clear_i ? '0 : !pop_i ? rd_q : (rd_q == LastPtr) ? '0 : rd_q + PtrW'(1);
        cnt_d = clear_i ? '0 : cnt_q + CntW'(push_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

`ifndef SYNTHESIS
    // The dispatcher stops granting at MaxOutstanding, so a full FIFO is never pushed.
    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i) !(push_i && full_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i) !(pop_i && empty_o));
`endif

endmodule

// File: rtl/idma_job_dispatcher.sv
// idma_job_dispatcher: round-robin dispatch of 2D iDMA jobs onto the AXI2OBI/OBI2AXI channels.
// Defining IDMA_DISPATCH_PERF_EN adds per-channel job handshake counters on perf_jobs_o.
module idma_job_dispatcher
    import redmule_tile_pkg::*;
#(
    parameter int unsigned  NumReq         = iDMA_DispatchNumReq,
    parameter int unsigned  MaxOutstanding = iDMA_DispatchMaxOutstanding,
    parameter type          job_t          = idma_nd_req_t,
    localparam int unsigned ReqIdxW        = idx_width(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  job_t [NumReq-1:0]       req_job_i,
    input  logic [NumReq-1:0]       req_dir_i,
    output logic [1:0]              ch_valid_o,
    input  logic [1:0]              ch_ready_i,
    output job_t [1:0]              ch_job_o,
    input  logic [1:0]              ch_done_i,
    output logic [1:0]              cpl_valid_o,
    output logic [1:0][ReqIdxW-1:0] cpl_req_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [1:0][31:0]        perf_jobs_o
);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [ReqIdxW-1:0] LastReq = ReqIdxW'(NumReq - 1);

    logic [1:0]               accept, push, pop, fifo_full, fifo_empty;
    logic [NumReq-1:0]        elig;
    logic                     gnt_valid;
    logic [ReqIdxW-1:0]       gnt_idx, rr_q, rr_d;
    idma_transfer_ch_e        gnt_dir;
    logic [1:0][OutW-1:0]     out_q, out_d;
    logic [1:0]               ch_valid_q, ch_valid_d, cpl_valid_q, cpl_valid_d;
    job_t [1:0]               ch_job_q, ch_job_d;
    logic [1:0][ReqIdxW-1:0]  fifo_head, cpl_req_q, cpl_req_d;
    logic                     err_q, err_d;

    // The FIFO fill level tracks out_q exactly, so its full flag doubles as the outstanding limit.
    assign accept = (~ch_valid_q | ch_ready_i) & ~fifo_full;

    always_comb begin
        elig      = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < int'(NumReq); i++)
            elig[i] = req_valid_i[i] & accept[req_dir_i[i]] & ~clear_i;
        for (int k = 0; k < int'(NumReq); k++) begin
            if (!gnt_valid && elig[ReqIdxW'((int'(rr_q) + k) % int'(NumReq))]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ReqIdxW'((int'(rr_q) + k) % int'(NumReq));
            end
        end
        gnt_dir     = idma_transfer_ch_e'(req_dir_i[gnt_idx]);
        req_ready_o = gnt_valid ? (NumReq'(1) << gnt_idx) : '0;
        rr_d        = clear_i ? '0 : !gnt_valid ? rr_q : (gnt_idx == LastReq) ? '0 : gnt_idx + ReqIdxW'(1);
    end

    always_comb begin
        push = '0;
        if (gnt_valid) push[gnt_dir] = 1'b1;
        // A done with nothing outstanding is flagged, never popped.
        pop   = ch_done_i & ~fifo_empty;
        err_d = err_q;
        for (int c = 0; c < 2; c++) begin
            err_d          = err_d | (ch_done_i[c] & (out_q[c] == '0));
            out_d[c]       = clear_i ? '0 : out_q[c] + OutW'(push[c]) - OutW'(pop[c]);
            ch_valid_d[c]  = ~clear_i & (push[c] | (ch_valid_q[c] & ~ch_ready_i[c]));
            ch_job_d[c]    = clear_i ? '0 : push[c] ? req_job_i[gnt_idx] : ch_job_q[c];
            cpl_valid_d[c] = ~clear_i & pop[c];
            cpl_req_d[c]   = clear_i ? '0 : pop[c] ? fifo_head[c] : cpl_req_q[c];
        end
        err_d = err_d & ~clear_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            out_q       <= '0;
            ch_valid_q  <= '0;
            ch_job_q    <= '0;
            cpl_valid_q <= '0;
            cpl_req_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            out_q       <= out_d;
            ch_valid_q  <= ch_valid_d;
            ch_job_q    <= ch_job_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_req_q   <= cpl_req_d;
            err_q       <= err_d;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        idma_dispatch_tag_fifo #(
            .Depth (MaxOutstanding),
            .Width (ReqIdxW)
        ) u_tag_fifo (
            .clk_i,
            .rst_ni,
            .clear_i,
            .push_i  (push[c]),
            .data_i  (gnt_idx),
            .pop_i   (pop[c]),
            .data_o  (fifo_head[c]),
            .full_o  (fifo_full[c]),
            .empty_o (fifo_empty[c])
        );
    end

    assign ch_valid_o  = ch_valid_q;
    assign ch_job_o    = ch_job_q;
    assign cpl_valid_o = cpl_valid_q;
    assign cpl_req_o   = cpl_req_q;
    assign err_o       = err_q;
    assign busy_o      = (|out_q) | (|ch_valid_q);

`ifdef IDMA_DISPATCH_PERF_EN
    logic [1:0][31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_q <= '0;
        else for (int c = 0; c < 2; c++) perf_q[c] <= clear_i ? '0 : perf_q[c] + 32'(ch_valid_q[c] & ch_ready_i[c]);
    end

    assign perf_jobs_o = perf_q;
`else
    assign perf_jobs_o = '0;
`endif

endmodule

// File: tb/tb_idma_job_dispatcher.sv
// tb_idma_job_dispatcher: randomized phases against a queue-based reference model with a scoreboard monitor.
module tb_idma_job_dispatcher;
    import redmule_tile_pkg::*;

    localparam int NR   = int'(iDMA_DispatchNumReq);
    localparam int MAXO = int'(iDMA_DispatchMaxOutstanding);
    localparam int IW   = int'(idx_width(iDMA_DispatchNumReq));

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic [NR-1:0]        req_valid_i = '0, req_ready_o, req_dir_i = '0;
    idma_nd_req_t [NR-1:0] req_job_i = '0;
    logic [1:0]           ch_valid_o, ch_ready_i = '0, ch_done_i = '0, cpl_valid_o;
    idma_nd_req_t [1:0]   ch_job_o;
    logic [1:0][IW-1:0]   cpl_req_o;
    logic                 busy_o, err_o;
    logic [1:0][31:0]     perf_jobs_o;

    idma_job_dispatcher dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_job_i   (req_job_i),
        .req_dir_i   (req_dir_i),
        .ch_valid_o  (ch_valid_o),
        .ch_ready_i  (ch_ready_i),
        .ch_job_o    (ch_job_o),
        .ch_done_i   (ch_done_i),
        .cpl_valid_o (cpl_valid_o),
        .cpl_req_o   (cpl_req_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .perf_jobs_o (perf_jobs_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] rdy;
        logic [1:0]    chv;
        logic          busy;
        logic          err;
        logic [63:0]   perf;
    } exp_t;
    typedef struct {
        int idx;
        int due;
    } cpl_t;

    exp_t         cyc_q[$];
    cpl_t         cpl_q[2][$];
    idma_nd_req_t job_q[2][$];
    int           vectors = 0, miscompares = 0, cyc = 0;

    // Reference model: requester tags in flight per channel, register occupancy, sticky error, job counts.
    int          tags[2][$];
    bit          regv[2];
    bit          merr;
    logic [31:0] mperf[2];
    int          rr, granted, gi;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s @%0d: got an event, expected none", nm, cyc);
    endtask

    function automatic idma_nd_req_t rand_job();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cpl_t p;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("req_ready", 256'(req_ready_o), 256'(e.rdy));
            check("ch_valid", 256'(ch_valid_o), 256'(e.chv));
            check("busy", 256'(busy_o), 256'(e.busy));
            check("err", 256'(err_o), 256'(e.err));
            check("perf_jobs", 256'({perf_jobs_o[1], perf_jobs_o[0]}), 256'(e.perf));
            for (int c = 0; c < 2; c++) begin
                if (ch_valid_o[c] && ch_ready_i[c]) begin
                    if (job_q[c].size() == 0) unexpected("ch_job_handshake");
                    else check("ch_job", 256'(ch_job_o[c]), 256'(job_q[c].pop_front()));
                end
                if (cpl_q[c].size() > 0 && cpl_q[c][0].due <= cyc) begin
                    p = cpl_q[c].pop_front();
                    check("cpl_valid", 256'(cpl_valid_o[c]), 256'(1));
                    check("cpl_req", 256'(cpl_req_o[c]), 256'(p.idx));
                end else if (cpl_valid_o[c]) begin
                    unexpected("cpl_valid");
                end
            end
        end
    end

    // {cycles, %valid, %dir1, %ready0, %ready1, %done, done-when-empty allowed}
    int ph[7][7] = '{
        '{600,  70,  50,  80,  80, 25, 0},
        '{ 40, 100,   0, 100, 100,  0, 0},
        '{300,  90,  50,   0,  90, 20, 0},
        '{300, 100, 100, 100, 100, 40, 0},
        '{300,  60,  50,  50,  50, 35, 1},
        '{600,  80,  50,  70,  70, 30, 0},
        '{ 10,   0,   0, 100, 100,  0, 0}
    };

    initial begin
        exp_t       e;
        bit         clr;
        logic [1:0] acc;
        int         c;
        rr = 0; granted = -1; merr = 0;
        regv = '{0, 0};
        mperf = '{0, 0};
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready_o), 256'(0));
        check("rst_ch_valid", 256'(ch_valid_o), 256'(0));
        check("rst_ch_job", 256'(ch_job_o), 256'(0));
        check("rst_cpl_valid", 256'(cpl_valid_o), 256'(0));
        check("rst_cpl_req", 256'(cpl_req_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_err", 256'(err_o), 256'(0));
        check("rst_perf", 256'(perf_jobs_o), 256'(0));
        for (int p = 0; p < 7; p++) begin
            for (int n = 0; n < ph[p][0]; n++) begin
                @(posedge clk);
                #1;
                clr = (p > 0 && n == 0);
                for (int i = 0; i < NR; i++) begin
                    if (!req_valid_i[i] || granted == i) begin
                        req_valid_i[i] = $urandom_range(99) < ph[p][1];
                        req_dir_i[i]   = $urandom_range(99) < ph[p][2];
                        req_job_i[i]   = rand_job();
                    end
                end
                clear_i       = clr;
                ch_ready_i[0] = !clr && $urandom_range(99) < ph[p][3];
                ch_ready_i[1] = !clr && $urandom_range(99) < ph[p][4];
                for (int k = 0; k < 2; k++)
                    ch_done_i[k] = !clr && (tags[k].size() > 0 || ph[p][6] != 0) && $urandom_range(99) < ph[p][5];
                for (int k = 0; k < 2; k++)
                    acc[k] = (!regv[k] || ch_ready_i[k]) && tags[k].size() < MAXO;
                gi = -1;
                if (!clr)
                    for (int k = 0; k < NR; k++)
                        if (gi < 0 && req_valid_i[(rr + k) % NR] && acc[req_dir_i[(rr + k) % NR]]) gi = (rr + k) % NR;
                e.rdy  = '0;
                if (gi >= 0) e.rdy[gi] = 1'b1;
                e.chv  = {regv[1], regv[0]};
                e.busy = regv[0] || regv[1] || tags[0].size() > 0 || tags[1].size() > 0;
                e.err  = merr;
`ifdef IDMA_DISPATCH_PERF_EN
                e.perf = {mperf[1], mperf[0]};
`else
                e.perf = '0;
`endif
                cyc_q.push_back(e);
                if (clr) begin
                    for (int k = 0; k < 2; k++) begin
                        tags[k].delete();
                        job_q[k].delete();
                        regv[k]  = 0;
                        mperf[k] = '0;
                    end
                    merr = 0;
                    rr   = 0;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (regv[k] && ch_ready_i[k]) mperf[k] = mperf[k] + 32'd1;
                        if (ch_done_i[k]) begin
                            if (tags[k].size() > 0) cpl_q[k].push_back('{idx: tags[k].pop_front(), due: cyc + 1});
                            else merr = 1;
                        end
                        regv[k] = regv[k] && !ch_ready_i[k];
                    end
                    if (gi >= 0) begin
                        c       = int'(req_dir_i[gi]);
                        regv[c] = 1;
                        tags[c].push_back(gi);
                        job_q[c].push_back(req_job_i[gi]);
                        rr      = (gi + 1) % NR;
                    end
                end
                granted = gi;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("drain_jobs", 256'(job_q[k].size()), 256'(0));
            check("drain_cpls", 256'(cpl_q[k].size()), 256'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
